// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants, RLE word fields and decoder state type
package frame_pkg;

    localparam int GRID_W      = 40;
    localparam int GRID_H      = 30;
    localparam int BUFFER_SIZE = GRID_W * GRID_H;
    localparam int NUM_FRAMES  = 3286;

    // RLE word: colour in the top bit, (run length - 1) below it
    localparam int COLOUR_BIT  = 7;
    localparam int LEN_MSB     = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/rle_frame_decoder_if.sv
// rtl/rle_frame_decoder_if.sv - ROM read port and frame buffer write port bundle
interface rle_frame_decoder_if #(
    parameter int ROM_AW = 18
);

    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              wr_en;
    logic [10:0]       wr_addr;
    logic              wr_data;

    modport master (
        output rom_addr,
        input  rom_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/rle_frame_decoder.sv
// rtl/rle_frame_decoder.sv - expands RLE frames from ROM into per-block frame buffer writes
module rle_frame_decoder
    import frame_pkg::*;
#(
    parameter int HPIXELS    = 640,
    parameter int VPIXELS    = 480,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_FRAMES = 3286,
    parameter int ROM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    rle_frame_decoder_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic [11:0]         frame_num,
    output logic                overrun,
    output logic                fmt_err
);

    localparam int          NUM_BLOCKS = (HPIXELS / BLOCK_SIZE) * (VPIXELS / BLOCK_SIZE);
    localparam logic [10:0] LAST_BLK   = 11'(NUM_BLOCKS - 1);
    localparam logic [11:0] LAST_FRAME = 12'(NUM_FRAMES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_colour;
    logic [7:0]        r_run;
    logic [10:0]       r_blk;
    logic [11:0]       r_frame_num;
    logic              r_overrun;
    logic              r_fmt_err;
    logic              w_last_blk;
    logic              w_run_end;

    assign w_last_blk = (r_blk == LAST_BLK);
    assign w_run_end  = (r_run == 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame end is decided purely by block count, so a run that overshoots
    // is cut at the last block and a short frame borrows the next word.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_tick) w_next = FETCH;
            FETCH:   w_next = LOAD;
            LOAD:    w_next = EMIT;
            EMIT: begin
                if (w_last_blk) begin
                    w_next = DONE;
                end else if (w_run_end) begin
                    w_next = FETCH;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_addr  <= '0;
            r_colour    <= 1'b0;
            r_run       <= 8'd0;
            r_blk       <= 11'd0;
            r_frame_num <= 12'd0;
            r_overrun   <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else begin
            if (frame_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                LOAD: begin
                    r_colour <= bus.rom_data[COLOUR_BIT];
                    r_run    <= {1'b0, bus.rom_data[LEN_MSB:0]} + 8'd1;
                end
                EMIT: begin
                    if (w_last_blk) begin
                        if (!w_run_end) begin
                            r_fmt_err <= 1'b1;
                        end
                    end else begin
                        r_blk <= r_blk + 11'd1;
                        r_run <= r_run - 8'd1;
                        if (w_run_end) begin
                            r_rom_addr <= r_rom_addr + ROM_AW'(1);
                        end
                    end
                end
                // The word holding the frame's last block is retired here,
                // so a truncated run is skipped along with it.
                DONE: begin
                    r_blk <= 11'd0;
                    if (r_frame_num == LAST_FRAME) begin
                        r_frame_num <= 12'd0;
                        r_rom_addr  <= '0;
                    end else begin
                        r_frame_num <= r_frame_num + 12'd1;
                        r_rom_addr  <= r_rom_addr + ROM_AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.wr_en    = (r_state == EMIT);
    assign bus.wr_addr  = r_blk;
    assign bus.wr_data  = r_colour;

    assign busy       = (r_state == FETCH) || (r_state == LOAD) || (r_state == EMIT);
    assign frame_done = (r_state == DONE);
    assign frame_num  = r_frame_num;
    assign overrun    = r_overrun;
    assign fmt_err    = r_fmt_err;

endmodule
